// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester bridging a valid/ready command port onto APB
// Ports:
//   clk, resetn                     clock and asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_write, cmd_addr, cmd_wdata describe it
//   rsp_valid                       one-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout   result of the last transfer, held until the next pulse
//   psel, penable, pwrite, addr, pwdata, pready, pslverr, prdata   APB requester side
// Define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES wait states.
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [4:0]  addr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  state_e      state_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [4:0]  addr_q;
  logic [31:0] pwdata_q;
  logic [31:0] rsp_rdata_q;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;
  logic          rsp_timeout_q;
  assign wait_d      = wait_q + 1'b1;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif
  assign cmd_ready = state_q == IDLE;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign addr      = addr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      addr_q      <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_q        <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          state_q  <= SETUP;
          psel_q   <= 1'b1;
          pwrite_q <= cmd_write;
          addr_q   <= cmd_addr;
          // reads keep the previous write data on the bus
          if (cmd_write) pwdata_q <= cmd_wdata;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_q    <= '0;
`endif
        end
        ACCESS: if (pready) begin
          // a ready slave wins over a watchdog expiring on the same edge
          state_q     <= IDLE;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= pslverr;
          rsp_rdata_q <= pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_q <= 1'b0;
`endif
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_d == WW'(TIMEOUT_CYCLES)) begin
          state_q       <= IDLE;
          psel_q        <= 1'b0;
          penable_q     <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_err_q     <= 1'b1;
          rsp_rdata_q   <= '0;
          rsp_timeout_q <= 1'b1;
        end else begin
          wait_q <= wait_d;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed checks of apb_master against a transaction-level model
module tb_apb_master;
  localparam int TMO = 4;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  addr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;
  int checks = 0;
  int passed = 0;
  int fails = 0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        m_tmo = 1'b0;

  apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .addr(addr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_held();
    chk32("rsp_rdata_held", rsp_rdata, m_rdata);
    chk1("rsp_err_held", rsp_err, m_err);
    chk1("rsp_timeout_held", rsp_timeout, m_tmo);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk1("idle_rsp_valid", rsp_valid, 1'b0);
      chk1("idle_psel", psel, 1'b0);
      chk1("idle_penable", penable, 1'b0);
      chk1("idle_cmd_ready", cmd_ready, 1'b1);
      chk_held();
    end
  endtask

  // Issue one command and play the slave; called at a negedge with the master idle.
  task automatic start(input logic w, input logic [4:0] a, input logic [31:0] d, input logic keep);
    chk1("start_cmd_ready", cmd_ready, 1'b1);
    chk1("start_psel", psel, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    pready    = 1'($urandom);
    pslverr   = 1'($urandom);
    if (w) m_pwdata = d;
    @(negedge clk);
    chk1("setup_psel", psel, 1'b1);
    chk1("setup_penable", penable, 1'b0);
    chk1("setup_cmd_ready", cmd_ready, 1'b0);
    chk1("setup_rsp_valid", rsp_valid, 1'b0);
    chk32("setup_addr", 32'(addr), 32'(a));
    chk1("setup_pwrite", pwrite, w);
    chk32("setup_pwdata", pwdata, m_pwdata);
    chk_held();
    if (!keep) begin
      cmd_write = 1'($urandom);
      cmd_addr  = 5'($urandom);
      cmd_wdata = $urandom;
    end
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    @(negedge clk);
  endtask

  task automatic access_cycle(input logic w, input logic [4:0] a, input logic rdy);
    chk1("access_psel", psel, 1'b1);
    chk1("access_penable", penable, 1'b1);
    chk1("access_cmd_ready", cmd_ready, 1'b0);
    chk1("access_rsp_valid", rsp_valid, 1'b0);
    chk32("access_addr", 32'(addr), 32'(a));
    chk1("access_pwrite", pwrite, w);
    chk32("access_pwdata", pwdata, m_pwdata);
    pready = rdy;
  endtask

  task automatic check_done();
    chk1("done_rsp_valid", rsp_valid, 1'b1);
    chk32("done_rsp_rdata", rsp_rdata, m_rdata);
    chk1("done_rsp_err", rsp_err, m_err);
    chk1("done_rsp_timeout", rsp_timeout, m_tmo);
    chk1("done_psel", psel, 1'b0);
    chk1("done_penable", penable, 1'b0);
    chk1("done_cmd_ready", cmd_ready, 1'b1);
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
  endtask

  task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d, input int waits,
                      input logic err, input logic [31:0] rd, input logic keep);
    start(w, a, d, keep);
    for (int k = 0; k <= waits; k++) begin
      access_cycle(w, a, k == waits);
      pslverr = (k == waits) ? err : 1'($urandom);
      prdata  = (k == waits) ? rd : $urandom;
      @(negedge clk);
    end
    m_rdata = w ? 32'h0 : rd;
    m_err   = err;
    m_tmo   = 1'b0;
    check_done();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic xfer_timeout(input logic w, input logic [4:0] a, input logic [31:0] d);
    start(w, a, d, 1'b0);
    for (int k = 0; k < TMO; k++) begin
      access_cycle(w, a, 1'b0);
      pslverr = 1'($urandom);
      @(negedge clk);
    end
    m_rdata = 32'h0;
    m_err   = 1'b1;
    m_tmo   = 1'b1;
    check_done();
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    chk1("reset_psel", psel, 1'b0);
    chk1("reset_penable", penable, 1'b0);
    chk1("reset_pwrite", pwrite, 1'b0);
    chk32("reset_addr", 32'(addr), 32'h0);
    chk32("reset_pwdata", pwdata, 32'h0);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_cmd_ready", cmd_ready, 1'b1);
    chk_held();
    resetn = 1'b1;
    xfer(1'b1, 5'h0A, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0);
    idle(1);
    xfer(1'b0, 5'h0A, 32'h12345678, 2, 1'b0, 32'hDEADBEEF, 1'b0);
    idle(2);
    xfer(1'b0, 5'h1F, 32'h0, 0, 1'b1, 32'hCAFEF00D, 1'b0);
    idle(1);
    xfer(1'b1, 5'h03, 32'hA5A5A5A5, 1, 1'b0, 32'h0, 1'b1);
    xfer(1'b1, 5'h03, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b1);
    idle(1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 5'h11;
    cmd_wdata = 32'h0BADF00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    pready    = 1'b0;
    @(negedge clk);
    chk1("pre_reset_penable", penable, 1'b1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    m_pwdata = 32'h0;
    m_rdata  = 32'h0;
    m_err    = 1'b0;
    m_tmo    = 1'b0;
    chk1("async_reset_psel", psel, 1'b0);
    chk1("async_reset_penable", penable, 1'b0);
    chk32("async_reset_addr", 32'(addr), 32'h0);
    chk32("async_reset_pwdata", pwdata, 32'h0);
    chk1("async_reset_rsp_valid", rsp_valid, 1'b0);
    chk_held();
    @(negedge clk);
    resetn = 1'b1;
    idle(2);
    xfer(1'b0, 5'h07, 32'h0, 1, 1'b0, 32'h600DCAFE, 1'b0);
    idle(1);
`ifdef APB_MASTER_TIMEOUT_EN
    xfer_timeout(1'b0, 5'h15, 32'h0);
    idle(1);
    xfer(1'b1, 5'h16, 32'h13572468, TMO - 1, 1'b0, 32'h0, 1'b0);
    idle(1);
`else
    xfer(1'b1, 5'h15, 32'h13572468, 100, 1'b0, 32'h0, 1'b0);
    idle(1);
`endif
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom),
           $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
